// File: rtl/load_store_unit.sv
// Load/store unit: sits between the core and a word-wide, asynchronous-read data memory.
// Handles byte/half/word loads with sign or zero extension, and uses read-modify-write for sub-word stores.
module load_store_unit #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [DATA_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wd,
  input  logic [DATA_WIDTH-1:0] mem_rd
);
  localparam int NUM_LANES = DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;

  typedef struct packed {
    logic                  we;
    logic [1:0]            size;
    logic                  uns;
    logic [DATA_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } req_t;

  state_t                state, state_nxt;
  req_t                  r;
  logic                  req_err, err_q;
  logic [DATA_WIDTH-1:0] word_idx, rd_sh, load_fmt, wrep, merged, merged_q, rdata_q;
  logic [NUM_LANES-1:0]  be;

  // Error decode on the live request, so a bad access goes straight to RESP.
  always_comb begin
    req_err = 1'b0;
    case (req_size)
      2'b11:   req_err = 1'b1;
      2'b01:   req_err = req_addr[0];
      2'b10:   req_err = (req_addr[1:0] != 2'b00);
      default: req_err = 1'b0;
    endcase
    if ((req_addr >> (ADDR_WIDTH + 2)) != '0) req_err = 1'b1;
  end

  assign word_idx = DATA_WIDTH'(r.addr[ADDR_WIDTH+1:2]);

  // Load formatting: shift the addressed lane down, then extend.
  assign rd_sh = mem_rd >> {r.addr[1:0], 3'b000};
  always_comb begin
    case (r.size)
      2'b00:   load_fmt = r.uns ? {{(DATA_WIDTH-8){1'b0}}, rd_sh[7:0]}
                                : {{(DATA_WIDTH-8){rd_sh[7]}}, rd_sh[7:0]};
      2'b01:   load_fmt = r.uns ? {{(DATA_WIDTH-16){1'b0}}, rd_sh[15:0]}
                                : {{(DATA_WIDTH-16){rd_sh[15]}}, rd_sh[15:0]};
      default: load_fmt = mem_rd;
    endcase
  end

  // Store merge: replicate the store data across lanes and pick the addressed ones.
  always_comb begin
    case (r.size)
      2'b00:   be = NUM_LANES'(1) << r.addr[1:0];
      2'b01:   be = NUM_LANES'(3) << {r.addr[1], 1'b0};
      default: be = '1;
    endcase
    wrep = (r.size == 2'b00) ? {NUM_LANES{r.wdata[7:0]}} : {(NUM_LANES/2){r.wdata[15:0]}};
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign merged[8*i +: 8] = be[i] ? wrep[8*i +: 8] : mem_rd[8*i +: 8];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wd    = '0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = req_err ? RESP : ACCESS;
      end
      ACCESS: begin
        mem_addr = word_idx;
        if (r.we && r.size == 2'b10) begin
          mem_we    = 1'b1;
          mem_wd    = r.wdata;
          state_nxt = RESP;
        end else if (r.we) begin
          state_nxt = WRITE;
        end else begin
          state_nxt = RESP;
        end
      end
      WRITE: begin
        mem_addr  = word_idx;
        mem_we    = 1'b1;
        mem_wd    = merged_q;
        state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r        <= '0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      merged_q <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          r       <= '{we: req_we, size: req_size, uns: req_unsigned,
                       addr: req_addr, wdata: req_wdata};
          err_q   <= req_err;
          rdata_q <= '0;
        end
        ACCESS: begin
          if (!r.we) rdata_q <= load_fmt;
          merged_q <= merged;
        end
        RESP: if (rsp_ready) begin
          err_q   <= 1'b0;
          rdata_q <= '0;
        end
        default: ;
      endcase
    end
  end

  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a behavioural word memory model, latency and pulse-count checks,
// response stall, error cases and reset during a read-modify-write.
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wd, mem_rd;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          pulses;
  } exp_t;
  exp_t sb[$];

  logic [31:0] mem [0:31];
  int          we_cnt = 0;
  logic        prev_we = 1'b0;
  logic        we_twice = 1'b0;
  logic [31:0] last_waddr = '0;
  int          checks = 0;
  int          failures = 0;

  load_store_unit #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  assign mem_rd = mem[mem_addr[4:0]];

  always @(posedge clk) begin
    prev_we <= mem_we;
    if (mem_we) begin
      mem[mem_addr[4:0]] <= mem_wd;
      we_cnt             <= we_cnt + 1;
      last_waddr         <= mem_addr;
      if (prev_we) we_twice <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic xact(input logic we, input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rd, input logic exp_err,
                      input int exp_lat, input int stall);
    exp_t e;
    int   lat;
    int   n;
    int   w0;
    e.rdata  = exp_rd;
    e.err    = exp_err;
    e.lat    = exp_lat;
    e.pulses = (we && !exp_err) ? 1 : 0;
    sb.push_back(e);
    n = 0;
    while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
    chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
    w0 = we_cnt;
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    // scramble inputs while busy; the access in flight must not notice
    req_we = ~we; req_size = ~size; req_unsigned = ~uns;
    req_addr = $urandom; req_wdata = $urandom;
    lat = 1;
    while (!rsp_valid && lat < 10) begin @(posedge clk); #1; lat++; end
    req_valid = 1'b0;
    e = sb.pop_front();
    chk("latency", lat, e.lat);
    chk("rsp_rdata", rsp_rdata, e.rdata);
    chk("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      chk("stall_valid", {31'b0, rsp_valid}, 32'd1);
      chk("stall_rdata", rsp_rdata, e.rdata);
      chk("stall_req_ready", {31'b0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("rsp_done", {31'b0, rsp_valid}, 32'd0);
    chk("we_pulses", we_cnt - w0, e.pulses);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'h0101_0101 * i;
    mem[0] = 32'h80FF_7F01;
    mem[1] = 32'h1122_3344;
    mem[3] = 32'h1234_5678;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wd", mem_wd, 32'd0);
    @(negedge clk); rst_n = 1'b1; #1;
    chk("post_rst_ready", {31'b0, req_ready}, 32'd1);

    // byte loads from 0x80FF_7F01
    xact(1'b0, 2'b00, 1'b0, 32'h1, 32'h0, 32'h0000_007F, 1'b0, 2, 0);
    xact(1'b0, 2'b00, 1'b0, 32'h2, 32'h0, 32'hFFFF_FFFF, 1'b0, 2, 0);
    xact(1'b0, 2'b00, 1'b1, 32'h3, 32'h0, 32'h0000_0080, 1'b0, 2, 0);
    // half store into upper half of word 1
    xact(1'b1, 2'b01, 1'b0, 32'h6, 32'hAAAA_BEEF, 32'h0, 1'b0, 3, 0);
    chk("half_store_mem", mem[1], 32'hBEEF_3344);
    chk("half_store_addr", last_waddr, 32'd1);
    // word store then load back
    xact(1'b1, 2'b10, 1'b0, 32'h8, 32'hDEAD_BEEF, 32'h0, 1'b0, 2, 0);
    chk("word_store_addr", last_waddr, 32'd2);
    chk("word_store_mem", mem[2], 32'hDEAD_BEEF);
    xact(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 32'hDEAD_BEEF, 1'b0, 2, 0);
    // half loads, both extensions
    xact(1'b0, 2'b01, 1'b0, 32'h2, 32'h0, 32'hFFFF_80FF, 1'b0, 2, 0);
    xact(1'b0, 2'b01, 1'b1, 32'h6, 32'h0, 32'h0000_BEEF, 1'b0, 2, 0);
    // byte store lane 1
    xact(1'b1, 2'b00, 1'b0, 32'h1, 32'h0000_0055, 32'h0, 1'b0, 3, 0);
    chk("byte_store_mem", mem[0], 32'h80FF_5501);
    // error cases
    xact(1'b0, 2'b10, 1'b0, 32'h5,  32'h0, 32'h0, 1'b1, 1, 0);
    xact(1'b1, 2'b01, 1'b0, 32'h3,  32'hFFFF_FFFF, 32'h0, 1'b1, 1, 0);
    xact(1'b0, 2'b11, 1'b0, 32'h0,  32'h0, 32'h0, 1'b1, 1, 0);
    xact(1'b1, 2'b10, 1'b0, 32'h80, 32'hFFFF_FFFF, 32'h0, 1'b1, 1, 0);
    chk("err_mem0_intact", mem[0], 32'h80FF_5501);
    // response stall
    xact(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 32'hBEEF_3344, 1'b0, 2, 5);

    // reset during the ACCESS of a byte store to word 3
    begin
      int w0;
      w0 = we_cnt;
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
      req_addr = 32'hC; req_wdata = 32'h0000_00AA;
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("rmw_access_no_we", {31'b0, mem_we}, 32'd0);
      rst_n = 1'b0; #1;
      chk("abort_mem_we", {31'b0, mem_we}, 32'd0);
      chk("abort_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk); rst_n = 1'b1; #1;
      chk("abort_req_ready", {31'b0, req_ready}, 32'd1);
      repeat (4) @(posedge clk);
      #1;
      chk("abort_we_pulses", we_cnt - w0, 32'd0);
      chk("abort_mem3", mem[3], 32'h1234_5678);
    end

    xact(1'b0, 2'b00, 1'b1, 32'hD, 32'h0, 32'h0000_0056, 1'b0, 2, 0);
    chk("we_never_consecutive", {31'b0, we_twice}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5, giving log2 of the data memory depth in words.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, giving the word width in bits; the function below is defined for 32.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 req_valid  input  1  core access request.
REQ-007 req_ready  output  1  unit can accept a request; high only in IDLE.
REQ-008 req_we  input  1  1 = store, 0 = load.
REQ-009 req_size  input  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
REQ-010 req_unsigned  input  1  1 = zero-extend sub-word loads, 0 = sign-extend.
REQ-011 req_addr  input  DATA_WIDTH  byte address.
REQ-012 req_wdata  input  DATA_WIDTH  store data; the low bytes are used for sub-word stores.
REQ-013 rsp_valid  output  1  response available.
REQ-014 rsp_ready  input  1  core accepts the response.
REQ-015 rsp_rdata  output  DATA_WIDTH  formatted load data; 0 for stores and errors.
REQ-016 rsp_err  output  1  access was misaligned, out of range or illegal.
REQ-017 mem_we  output  1  data memory write enable.
REQ-018 mem_addr  output  DATA_WIDTH  word index into data memory: zero-extended req_addr[ADDR_WIDTH+1:2].
REQ-019 mem_wd  output  DATA_WIDTH  data memory write data.
REQ-020 mem_rd  input  DATA_WIDTH  data memory asynchronous read data.

Function
REQ-021 SHALL implement the states IDLE, ACCESS, WRITE and RESP.
REQ-022 On req_valid && req_ready, SHALL latch we, size, unsigned, addr and wdata, then go to ACCESS, or to RESP with err=1 if an error condition holds.
REQ-023 An error condition is any of: size=11; half with addr[0]=1; word with addr[1:0]!=0; any addr bit above ADDR_WIDTH+1 set.
REQ-024 An errored request SHALL cause no memory write, and SHALL return rsp_rdata=0 and rsp_err=1.
REQ-025 Load in ACCESS: SHALL capture mem_rd, select the byte or half by addr[1:0], extend it per the unsigned flag into rsp_rdata, then go to RESP.
REQ-026 Word store in ACCESS: SHALL assert mem_we=1 with mem_wd=wdata for exactly one cycle, then go to RESP.
REQ-027 Sub-word store in ACCESS: SHALL read mem_rd and register the merged word, with only the addressed byte or half replaced; mem_we SHALL stay 0.
REQ-028 Sub-word store in WRITE: SHALL assert mem_we=1 with the merged word for one cycle, then go to RESP.
REQ-029 In RESP, rsp_valid SHALL be 1 and SHALL hold rsp_rdata and rsp_err stable until rsp_ready; on rsp_valid && rsp_ready it SHALL go to IDLE.
REQ-030 Latency from the accept edge to rsp_valid SHALL be 2 cycles for loads and word stores, 3 for sub-word stores, and 1 for errors.
REQ-031 mem_addr SHALL be driven from the latched address in ACCESS and WRITE, and SHALL be 0 otherwise.
REQ-032 mem_we SHALL be 1 only in a store ACCESS for a word store, or in WRITE; it SHALL never be 1 in two consecutive cycles.
REQ-033 req_valid and input changes outside IDLE SHALL be ignored, with no effect on the access in progress.
REQ-034 Back-to-back use: the RESP-exit cycle returns to IDLE; a new request SHALL be accepted no earlier than the following cycle.

Reset
REQ-035 While rst_n=0: state=IDLE; rsp_valid, rsp_err, rsp_rdata, mem_we, mem_addr and mem_wd all 0.
REQ-036 Reset asserted mid-operation SHALL abort the access immediately, with no pending write issued after rst_n rises.
REQ-037 Once rst_n=1, req_ready SHALL be 1 in the first cycle.

Verification
REQ-038 Word at 0x0 holds 0x80FF_7F01; byte load addr 0x1, signed -> rsp_rdata=0x0000_007F; addr 0x2 signed -> 0xFFFF_FFFF; addr 0x3 unsigned -> 0x0000_0080; each rsp_valid 2 cycles after accept.
REQ-039 Word at 0x4 holds 0x1122_3344; half store addr 0x6, wdata 0xAAAA_BEEF -> exactly one mem_we pulse, 3 cycles after accept, writing 0xBEEF_3344 to word index 1.
REQ-040 Word store addr 0x8, data 0xDEAD_BEEF -> mem_we=1 with mem_addr=2 for one cycle; a following word load at 0x8 returns 0xDEAD_BEEF.
REQ-041 Errored requests -> rsp_err=1 after 1 cycle with mem_we never asserted: word load at 0x5; half store at 0x3; size=11; addr 0x80 with ADDR_WIDTH=5.
REQ-042 rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_rdata stay stable and req_ready=0 throughout; the response completes on the first rsp_ready=1 cycle.
REQ-043 rst_n pulsed low during the ACCESS of a sub-word store -> no mem_we pulse, memory unchanged, req_ready=1 after release.
